// File: rtl/rename_map_if.sv
// Rename-stage port bundle: decode-side input group, dispatch-side output group,
// commit recycling, flush and free-list occupancy.
interface rename_map_if #(
  parameter int RENAME_WIDTH    = 2,
  parameter int ARCH_REGS       = 32,
  parameter int PHY_REGS        = 64,
  parameter int ARCH_ADDR_WIDTH = $clog2(ARCH_REGS),
  parameter int PHY_ADDR_WIDTH  = $clog2(PHY_REGS)
);
  logic [RENAME_WIDTH-1:0]                      in_valid;
  logic [RENAME_WIDTH-1:0]                      in_rd_we;
  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0] in_rd;
  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0] in_rs1;
  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0] in_rs2;
  logic                                         in_ready;

  logic [RENAME_WIDTH-1:0]                      out_valid;
  logic                                         out_ready;
  logic [RENAME_WIDTH-1:0][PHY_ADDR_WIDTH-1:0]  out_prd;
  logic [RENAME_WIDTH-1:0][PHY_ADDR_WIDTH-1:0]  out_prs1;
  logic [RENAME_WIDTH-1:0][PHY_ADDR_WIDTH-1:0]  out_prs2;
  logic [RENAME_WIDTH-1:0][PHY_ADDR_WIDTH-1:0]  out_old_prd;

  logic [RENAME_WIDTH-1:0]                      cm_valid;
  logic [RENAME_WIDTH-1:0]                      cm_rd_we;
  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0] cm_rd;
  logic [RENAME_WIDTH-1:0][PHY_ADDR_WIDTH-1:0]  cm_prd;
  logic [RENAME_WIDTH-1:0][PHY_ADDR_WIDTH-1:0]  cm_old_prd;

  logic                                         flush;
  logic [PHY_ADDR_WIDTH-1:0]                    free_count;

  modport master (
    output in_valid, in_rd_we, in_rd, in_rs1, in_rs2, out_ready,
    output cm_valid, cm_rd_we, cm_rd, cm_prd, cm_old_prd, flush,
    input  in_ready, out_valid, out_prd, out_prs1, out_prs2, out_old_prd, free_count
  );

  modport slave (
    input  in_valid, in_rd_we, in_rd, in_rs1, in_rs2, out_ready,
    input  cm_valid, cm_rd_we, cm_rd, cm_prd, cm_old_prd, flush,
    output in_ready, out_valid, out_prd, out_prs1, out_prs2, out_old_prd, free_count
  );
endinterface

// File: rtl/rename_map.sv
// Superscalar register rename: speculative/committed RATs, circular free list,
// intra-group dependency bypass, commit recycling and flush recovery.
module rename_map #(
  parameter int RENAME_WIDTH    = 2,
  parameter int ARCH_REGS       = 32,
  parameter int PHY_REGS        = 64,
  parameter int ARCH_ADDR_WIDTH = $clog2(ARCH_REGS),
  parameter int PHY_ADDR_WIDTH  = $clog2(PHY_REGS)
) (
  input  logic         clk,
  input  logic         rst,
  rename_map_if.slave  rn
);
  localparam int W        = RENAME_WIDTH;
  localparam int FL_DEPTH = PHY_REGS - ARCH_REGS;
  localparam int FL_AW    = $clog2(FL_DEPTH);

  typedef logic [FL_AW:0]              ptr_t;
  typedef logic [PHY_ADDR_WIDTH-1:0]   phy_t;

  phy_t spec_rat   [ARCH_REGS];
  phy_t cm_rat     [ARCH_REGS];
  phy_t cm_rat_nxt [ARCH_REGS];
  phy_t fl_mem     [FL_DEPTH];

  ptr_t head, tail, cm_head;
  ptr_t fl_used, alloc_cnt, commit_cnt;
  ptr_t alloc_ptr [W];
  ptr_t cm_ptr    [W];

  logic [W-1:0] alloc, cm_en;
  phy_t prd [W], prs1 [W], prs2 [W], old_prd [W];
  logic accept;

  // Tail starts one full lap ahead of head so an untouched list reads as full.
  assign fl_used       = tail - head;
  assign rn.free_count = PHY_ADDR_WIDTH'(fl_used);
  assign rn.in_ready   = (fl_used >= ptr_t'(W)) && (!(|rn.out_valid) || rn.out_ready) && !rn.flush;
  assign accept        = (|rn.in_valid) && rn.in_ready;

  always_comb begin
    alloc_cnt = '0;
    for (int j = 0; j < W; j++) begin
      alloc[j]     = rn.in_valid[j] && rn.in_rd_we[j] && (rn.in_rd[j] != '0);
      alloc_ptr[j] = head + alloc_cnt;
      prd[j]       = alloc[j] ? fl_mem[alloc_ptr[j][FL_AW-1:0]] : '0;
      if (alloc[j]) alloc_cnt = alloc_cnt + ptr_t'(1);
    end
  end

  // Older slots are scanned oldest-first so the youngest matching writer wins.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      prs1[j]    = (rn.in_rs1[j] == '0) ? '0 : spec_rat[rn.in_rs1[j]];
      prs2[j]    = (rn.in_rs2[j] == '0) ? '0 : spec_rat[rn.in_rs2[j]];
      old_prd[j] = spec_rat[rn.in_rd[j]];
      for (int k = 0; k < W; k++) begin
        if (k < j && alloc[k]) begin
          if (rn.in_rd[k] == rn.in_rs1[j]) prs1[j]    = prd[k];
          if (rn.in_rd[k] == rn.in_rs2[j]) prs2[j]    = prd[k];
          if (rn.in_rd[k] == rn.in_rd[j])  old_prd[j] = prd[k];
        end
      end
      if (!alloc[j]) old_prd[j] = '0;
    end
  end

  always_comb begin
    cm_rat_nxt = cm_rat;
    commit_cnt = '0;
    for (int j = 0; j < W; j++) begin
      cm_en[j]  = rn.cm_valid[j] && rn.cm_rd_we[j] && (rn.cm_rd[j] != '0);
      cm_ptr[j] = tail + commit_cnt;
      if (cm_en[j]) begin
        cm_rat_nxt[rn.cm_rd[j]] = rn.cm_prd[j];
        commit_cnt              = commit_cnt + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= phy_t'(i);
        cm_rat[i]   <= phy_t'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++) fl_mem[i] <= phy_t'(ARCH_REGS + i);
      head           <= '0;
      tail           <= ptr_t'(FL_DEPTH);
      cm_head        <= '0;
      rn.out_valid   <= '0;
      rn.out_prd     <= '0;
      rn.out_prs1    <= '0;
      rn.out_prs2    <= '0;
      rn.out_old_prd <= '0;
    end else begin
      cm_rat  <= cm_rat_nxt;
      tail    <= tail + commit_cnt;
      cm_head <= cm_head + commit_cnt;
      for (int j = 0; j < W; j++)
        if (cm_en[j]) fl_mem[cm_ptr[j][FL_AW-1:0]] <= rn.cm_old_prd[j];

      if (rn.flush) begin
        spec_rat     <= cm_rat_nxt;
        head         <= cm_head + commit_cnt;
        rn.out_valid <= '0;
      end else if (accept) begin
        for (int j = 0; j < W; j++)
          if (alloc[j]) spec_rat[rn.in_rd[j]] <= prd[j];
        head         <= head + alloc_cnt;
        rn.out_valid <= rn.in_valid;
        for (int j = 0; j < W; j++) begin
          rn.out_prd[j]     <= prd[j];
          rn.out_prs1[j]    <= prs1[j];
          rn.out_prs2[j]    <= prs2[j];
          rn.out_old_prd[j] <= old_prd[j];
        end
      end else if (rn.out_ready) begin
        rn.out_valid <= '0;
      end
    end
  end
endmodule
